// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall controller for the 5-stage MIPS pipeline.
// Optional saturating stall counter enabled by defining FWD_STALL_CNT_EN.
module fwd_hazard_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_to_reg,
  input  logic        flush,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        stall,
  output logic [15:0] stall_count
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 16;

  localparam logic [SEL_W-1:0] SEL_EXMEM = 2'b10;
  localparam logic [SEL_W-1:0] SEL_MEMWB = 2'b01;
  localparam logic [SEL_W-1:0] SEL_RF    = 2'b00;
  localparam logic [REG_W-1:0] REG_ZERO  = REG_W'(0);

  logic [REG_W-1:0] r_ex_rs;
  logic [REG_W-1:0] r_ex_rt;
  logic [REG_W-1:0] r_ex_rd;
  logic             r_ex_wr;
  logic             r_ex_load;
  logic [REG_W-1:0] r_mem_rd;
  logic             r_mem_wr;
  logic [REG_W-1:0] r_wb_rd;
  logic             r_wb_wr;

  logic             w_ex_take;
  logic             w_ex_rd_hit;

  // Pick the newest in-flight producer of src; r0 always reads the register file.
  function automatic logic [SEL_W-1:0] pick_sel(
    input logic [REG_W-1:0] src,
    input logic             mem_wr,
    input logic [REG_W-1:0] mem_rd,
    input logic             wb_wr,
    input logic [REG_W-1:0] wb_rd
  );
    logic [SEL_W-1:0] sel;
    sel = SEL_RF;
    if (src != REG_ZERO) begin
      if (mem_wr && (mem_rd == src)) begin
        sel = SEL_EXMEM;
      end else if (wb_wr && (wb_rd == src)) begin
        sel = SEL_MEMWB;
      end
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a_sel = pick_sel(r_ex_rs, r_mem_wr, r_mem_rd, r_wb_wr, r_wb_rd);
    fwd_b_sel = pick_sel(r_ex_rt, r_mem_wr, r_mem_rd, r_wb_wr, r_wb_rd);
  end

  // Load in EX whose result the ID instruction needs next cycle.
  always_comb begin
    w_ex_rd_hit = (r_ex_rd == id_rs) || (r_ex_rd == id_rt);
    stall       = id_valid && r_ex_load && r_ex_wr && (r_ex_rd != REG_ZERO) && w_ex_rd_hit;
    w_ex_take   = id_valid && !stall && !flush;
  end

  // Pipeline tracking registers; EX gets a bubble unless ID advances cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_rs   <= REG_ZERO;
      r_ex_rt   <= REG_ZERO;
      r_ex_rd   <= REG_ZERO;
      r_ex_wr   <= 1'b0;
      r_ex_load <= 1'b0;
      r_mem_rd  <= REG_ZERO;
      r_mem_wr  <= 1'b0;
      r_wb_rd   <= REG_ZERO;
      r_wb_wr   <= 1'b0;
    end else begin
      r_mem_rd <= r_ex_rd;
      r_mem_wr <= r_ex_wr;
      r_wb_rd  <= r_mem_rd;
      r_wb_wr  <= r_mem_wr;
      if (w_ex_take) begin
        r_ex_rs   <= id_rs;
        r_ex_rt   <= id_rt;
        r_ex_rd   <= id_rd;
        r_ex_wr   <= id_reg_write;
        r_ex_load <= id_mem_to_reg;
      end else begin
        r_ex_rs   <= REG_ZERO;
        r_ex_rt   <= REG_ZERO;
        r_ex_rd   <= REG_ZERO;
        r_ex_wr   <= 1'b0;
        r_ex_load <= 1'b0;
      end
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating count of stall cycles, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= CNT_W'(0);
    end else if (stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_count = r_stall_cnt;
`else
  assign stall_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: expected EX-stage selects are queued when an
// instruction is presented in ID and checked once it occupies EX.
module tb_fwd_hazard_unit;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        id_mem_to_reg;
  logic        flush;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic        stall;
  logic [15:0] stall_count;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    string      name;
  } exp_t;

  exp_t sb_q[$];

  fwd_hazard_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .id_reg_write  (id_reg_write),
    .id_mem_to_reg (id_mem_to_reg),
    .flush         (flush),
    .fwd_a_sel     (fwd_a_sel),
    .fwd_b_sel     (fwd_b_sel),
    .stall         (stall),
    .stall_count   (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One pipeline cycle: called at a negedge, presents ID, checks stall, queues the
  // expected selects for whatever enters EX, then checks them at the next negedge.
  task automatic cyc(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic wr, input logic ld,
                     input logic fl, input logic exp_stall,
                     input logic [1:0] ea, input logic [1:0] eb, input string nm);
    exp_t e;
    id_valid      = v;
    id_rs         = rs;
    id_rt         = rt;
    id_rd         = rd;
    id_reg_write  = wr;
    id_mem_to_reg = ld;
    flush         = fl;
    #1;
    n_tests++;
    if (stall !== exp_stall) begin
      n_fail++;
      $display("FAIL %s stall: got %b expected %b", nm, stall, exp_stall);
    end
    e.a = ea;
    e.b = eb;
    e.name = nm;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    n_tests++;
    if (fwd_a_sel !== e.a) begin
      n_fail++;
      $display("FAIL %s fwd_a_sel: got %b expected %b", e.name, fwd_a_sel, e.a);
    end
    n_tests++;
    if (fwd_b_sel !== e.b) begin
      n_fail++;
      $display("FAIL %s fwd_b_sel: got %b expected %b", e.name, fwd_b_sel, e.b);
    end
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "bubble");
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0;
    id_reg_write = 1'b0; id_mem_to_reg = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({fwd_a_sel, fwd_b_sel, stall} !== 5'b0 || stall_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: got a=%b b=%b stall=%b cnt=%h expected zeros",
               fwd_a_sel, fwd_b_sel, stall, stall_count);
    end
    rst_n = 1'b1;
    bubbles(1);
  endtask

  task automatic test_reset_midstream();
    bubbles(3);
    cyc(1'b1, 5'd1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, "mid_lw_r3");
    id_valid = 1'b1; id_rs = 5'd3; id_rt = 5'd3; id_rd = 5'd5;
    id_reg_write = 1'b1; id_mem_to_reg = 1'b0; flush = 1'b0;
    #1;
    n_tests++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre_reset_stall: got %b expected 1", stall);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({fwd_a_sel, fwd_b_sel, stall} !== 5'b0) begin
      n_fail++;
      $display("FAIL mid_async_reset: got a=%b b=%b stall=%b expected 00 00 0",
               fwd_a_sel, fwd_b_sel, stall);
    end
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 5'd3, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "post_reset_use_r3");
  endtask

  task automatic test_back_to_back();
    bubbles(3);
    cyc(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "b2b_add_r3");
    cyc(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, "b2b_sub_dist1");
    bubbles(3);
    cyc(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "d2_add_r3");
    cyc(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "d2_unrel");
    cyc(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, "b2b_sub_dist2");
    bubbles(3);
    cyc(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "d3_add_r3");
    cyc(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "d3_unrel1");
    cyc(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "d3_unrel2");
    cyc(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "b2b_sub_dist3");
  endtask

  task automatic test_priority();
    bubbles(3);
    cyc(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "pri_add_r5");
    cyc(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "pri_or_r5");
    cyc(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, "pri_and");
  endtask

  task automatic test_load_use();
    bubbles(3);
    cyc(1'b1, 5'd1, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, "lu_lw_r4");
    cyc(1'b1, 5'd2, 5'd4, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, "lu_stall_bubble");
    cyc(1'b1, 5'd2, 5'd4, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, "lu_add_fwd");
    n_tests++;
`ifdef FWD_STALL_CNT_EN
    if (stall_count !== 16'd1) begin
      n_fail++;
      $display("FAIL lu_stall_count: got %0d expected 1", stall_count);
    end
`else
    if (stall_count !== 16'd0) begin
      n_fail++;
      $display("FAIL lu_stall_count_tied: got %0d expected 0", stall_count);
    end
`endif
  endtask

  task automatic test_r0_flush();
    bubbles(3);
    cyc(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "r0_add");
    cyc(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "r0_use_d1");
    cyc(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "r0_use_d2");
    bubbles(3);
    cyc(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, "r0_lw");
    cyc(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "r0_lw_use");
    bubbles(3);
    cyc(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "fl_add_r3");
    cyc(1'b1, 5'd3, 5'd3, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, "fl_alu_bubble");
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "fl_alu_after");
    bubbles(3);
    cyc(1'b1, 5'd1, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, "fl_lw_r4");
    cyc(1'b1, 5'd2, 5'd4, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, "fl_stall_bubble");
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "fl_ld_after");
  endtask

`ifdef FWD_STALL_CNT_EN
  task automatic test_saturation();
    int stalls;
    stalls = 0;
    id_valid = 1'b1; id_rs = 5'd4; id_rt = 5'd4; id_rd = 5'd4;
    id_reg_write = 1'b1; id_mem_to_reg = 1'b1; flush = 1'b0;
    while (stalls < 65540) begin
      @(negedge clk);
      if (stall === 1'b1) stalls++;
    end
    @(negedge clk);
    n_tests++;
    if (stall_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_stall_count: got %h expected ffff", stall_count);
    end
    id_valid = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    @(negedge clk);
    test_reset();
    test_reset_midstream();
    test_back_to_back();
    test_priority();
    test_load_use();
    test_r0_flush();
`ifdef FWD_STALL_CNT_EN
    test_saturation();
`endif
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
